// File: rtl/clk_monitor.sv
// Measures period and high time of a slow asynchronous clock or strobe in in_clk cycles,
// and tracks lock/loss of that signal with a small state machine.
module clk_monitor #(
    parameter int CNT_W   = 16,
    parameter int TIMEOUT = 1000
) (
    input  logic             in_clk,
    input  logic             rst_n,
    input  logic             slow_clk,
    output logic             rise_pulse,
    output logic             fall_pulse,
    output logic [CNT_W-1:0] period,
    output logic [CNT_W-1:0] high_time,
    output logic             period_valid,
    output logic             locked,
    output logic             lost,
    output logic [1:0]       o_dbg_state
);

    localparam int IDLE_W = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0]  CNT_MAX  = '1;
    localparam logic [IDLE_W-1:0] IDLE_MAX = IDLE_W'(TIMEOUT);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ARMED  = 2'd1,
        S_LOCKED = 2'd2,
        S_LOST   = 2'd3
    } state_t;

    logic              r_s1, r_s2, r_s3;
    logic [CNT_W-1:0]  r_pcnt, r_hcnt, r_hlatch;
    logic              r_fall_seen;
    logic [IDLE_W-1:0] r_idle;
    state_t            r_state;

    logic              w_rise, w_fall, w_timeout, w_update;
    logic [IDLE_W-1:0] w_idle_next;
    state_t            w_state_next;

    assign w_rise = r_s2 & ~r_s3;
    assign w_fall = ~r_s2 & r_s3;

    // Synchronizer plus history flop; pulses are registered copies of the edge terms.
    always_ff @(posedge in_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1       <= 1'b0;
            r_s2       <= 1'b0;
            r_s3       <= 1'b0;
            rise_pulse <= 1'b0;
            fall_pulse <= 1'b0;
        end else begin
            r_s1       <= slow_clk;
            r_s2       <= r_s1;
            r_s3       <= r_s2;
            rise_pulse <= w_rise;
            fall_pulse <= w_fall;
        end
    end

    always_ff @(posedge in_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pcnt      <= '0;
            r_hcnt      <= '0;
            r_hlatch    <= '0;
            r_fall_seen <= 1'b0;
        end else if (w_rise) begin
            r_pcnt      <= CNT_W'(1);
            r_hcnt      <= CNT_W'(1);
            r_fall_seen <= 1'b0;
        end else begin
            if (r_pcnt != CNT_MAX) r_pcnt <= r_pcnt + CNT_W'(1);
            if (r_s2 && r_hcnt != CNT_MAX) r_hcnt <= r_hcnt + CNT_W'(1);
            if (w_fall) begin
                r_hlatch    <= r_hcnt;
                r_fall_seen <= 1'b1;
            end
        end
    end

    // Loss is declared on the cycle the idle count arrives at TIMEOUT, not one later.
    assign w_idle_next = (w_rise || w_fall) ? '0 :
                         (r_idle == IDLE_MAX) ? r_idle : r_idle + IDLE_W'(1);
    assign w_timeout   = (w_idle_next == IDLE_MAX);

    always_ff @(posedge in_clk or negedge rst_n) begin
        if (!rst_n) r_idle <= '0;
        else        r_idle <= w_idle_next;
    end

    always_comb begin
        w_state_next = r_state;
        w_update     = 1'b0;
        case (r_state)
            S_IDLE:   if (w_rise) w_state_next = S_ARMED;
            S_ARMED,
            S_LOCKED: begin
                if (w_rise) begin
                    w_state_next = S_LOCKED;
                    w_update     = 1'b1;
                end else if (w_timeout) begin
                    w_state_next = S_LOST;
                end
            end
            S_LOST:   if (w_rise) w_state_next = S_ARMED;
            default:  w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge in_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            period       <= '0;
            high_time    <= '0;
            period_valid <= 1'b0;
        end else begin
            r_state      <= w_state_next;
            period_valid <= w_update;
            if (w_update) begin
                period    <= r_pcnt;
                high_time <= r_fall_seen ? r_hlatch : r_pcnt;
            end
        end
    end

    assign locked      = (r_state == S_LOCKED);
    assign lost        = (r_state == S_LOST);
    assign o_dbg_state = r_state;

endmodule

// File: doc/clk_monitor.md
CLK_MONITOR -- requirements
Module: clk_monitor

Interface
REQ-001 SHALL have parameter CNT_W, default 16, width of the period and high-time counters and outputs.
REQ-002 SHALL have parameter TIMEOUT, default 1000, number of in_clk cycles without any slow_clk edge before the loss condition.
REQ-003 SHALL have port in_clk  input  1  system clock; all logic on its rising edge.
REQ-004 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port slow_clk  input  1  slow clock or strobe under measurement (e.g. a divided clock); asynchronous to in_clk.
REQ-006 SHALL have port rise_pulse  output  1  one-cycle pulse per detected slow_clk rising edge.
REQ-007 SHALL have port fall_pulse  output  1  one-cycle pulse per detected slow_clk falling edge.
REQ-008 SHALL have port period  output  CNT_W  last measured rise-to-rise interval, in in_clk cycles.
REQ-009 SHALL have port high_time  output  CNT_W  last measured rise-to-fall interval, in in_clk cycles.
REQ-010 SHALL have port period_valid  output  1  one-cycle pulse when period/high_time update.
REQ-011 SHALL have port locked  output  1  high while state is LOCKED.
REQ-012 SHALL have port lost  output  1  high while state is LOST.

Function
REQ-013 SHALL pass slow_clk through a 2-flop synchronizer (s1, s2) plus a history flop s3; edge detection SHALL use only s2/s3.
REQ-014 SHALL register rise_pulse = s2 & ~s3 and fall_pulse = ~s2 & s3; a level change held stable at the input SHALL produce its pulse after the 3rd in_clk rising edge that samples the new level, for exactly 1 cycle.
REQ-015 SHALL keep a period counter that is cleared to 1 on each detected rise, otherwise increments by 1, saturating at 2^CNT_W-1 (no wrap).
REQ-016 SHALL keep a high counter that is cleared to 1 on each detected rise, increments while s2 is high, holds when low, saturates at 2^CNT_W-1.
REQ-017 SHALL implement states IDLE, ARMED, LOCKED, LOST.
REQ-018 IDLE -> ARMED on a detected rise; no period update.
REQ-019 ARMED -> LOCKED on a detected rise; LOCKED -> LOCKED on a detected rise; in both, period <= period counter value, high_time <= high counter value latched at the most recent fall (period counter value if no fall occurred), and period_valid pulses on the cycle those registers update.
REQ-020 SHALL keep an idle counter, cleared on any detected edge, otherwise incrementing and saturating at TIMEOUT.
REQ-021 ARMED or LOCKED -> LOST when the idle counter reaches TIMEOUT; IDLE SHALL NOT enter LOST.
REQ-022 LOST -> ARMED on a detected rise; period and high_time SHALL hold their last values in LOST, and period_valid SHALL NOT pulse on that rise.
REQ-023 A rise detected on the same cycle the idle counter reaches TIMEOUT SHALL take priority; the state takes the rise transition.
REQ-024 period, high_time, and state SHALL change only as described in REQ-018 to REQ-023; saturated counts SHALL be reported as 2^CNT_W-1.

Reset
REQ-025 On rst_n low, SHALL immediately clear s1/s2/s3, all counters, period, high_time, and all 1-bit outputs to 0, with state IDLE.
REQ-026 After rst_n deasserts, SHALL require two detected rises before the first period_valid, even mid-activity on slow_clk.
REQ-027 Reset asserted mid-measurement SHALL discard partial counts; no pulse SHALL be emitted during or because of reset.

Verification
REQ-028 slow_clk toggles every 2 in_clk cycles (period 4) -> after 2nd rise period=4, high_time=2, period_valid 1 cycle, locked=1; every later rise repeats these values.
REQ-029 TIMEOUT=16, locked run then slow_clk held low -> lost=1 exactly 16 cycles after the last fall pulse, locked=0, period still 4.
REQ-030 From LOST, resume period-6 (3 high/3 low) -> 1st rise: ARMED, no period_valid; 2nd rise: period=6, high_time=3, locked=1.
REQ-031 CNT_W=4, slow_clk period 20 (10 high) -> period=15 (saturated), high_time=10.
REQ-032 rst_n pulsed low mid-run at period 4 -> all outputs 0 during reset, then IDLE; first period_valid at 2nd post-reset rise with period=4.
